traffic_phase_sched: RTL and testbench
======================================

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 Parameter T_GREEN, default 7, green duration in seconds; legal range 1..31.
REQ-002 Parameter T_YELLOW, default 3, yellow duration in seconds; legal range 1..31.
REQ-003 Parameter T_ALLRED, default 1, all-red clearance in seconds; legal range 1..31.
REQ-004 Parameter T_WALK, default 5, pedestrian walk duration in seconds; legal range 1..31.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 tick  input  1  one-cycle 1 Hz enable pulse from the divider.
REQ-008 ped_req  input  1  pedestrian button; any-length pulse.
REQ-009 night  input  1  level; requests flashing-yellow night mode.
REQ-010 xanh_1, vang_1, do_1  output  1 each  direction-1 green, yellow, red lamps.
REQ-011 xanh_2, vang_2, do_2  output  1 each  direction-2 green, yellow, red lamps.
REQ-012 walk  output  1  pedestrian walk lamp.
REQ-013 ped_ack  output  1  one-cycle pulse when a pedestrian request is serviced.
REQ-014 count_1, count_2  output  7 each  seconds until that direction's next lamp change (binary).

Function
REQ-015 States: G1, Y1, AR1, G2, Y2, AR2, PED, FLASH; 5-bit phase timer; pend flag; next_dir flag.
REQ-016 On entry to a timed state, load the timer with its duration: G* to T_GREEN, Y* to T_YELLOW, AR* to T_ALLRED, PED to T_WALK.
REQ-017 On a tick with timer greater than 1, decrement the timer; on a tick with timer equal to 1, take the transition on that clock edge; the timer is never 0 in a timed state.
REQ-018 Transitions:
  - G1 to Y1; Y1 to AR1.
  - AR1 to FLASH if night, else PED if pend (next_dir=2), else G2.
  - G2 to Y2; Y2 to AR2.
  - AR2 to FLASH if night, else PED if pend (next_dir=1), else G1.
  - PED to G(next_dir).
REQ-019 Lamps are registered and one-hot per direction.
  - G1: xanh_1, do_2.  Y1: vang_1, do_2.
  - G2: do_1, xanh_2.  Y2: do_1, vang_2.
  - AR1/AR2/PED: do_1, do_2; walk=1 only in PED.
REQ-020 pend sets on any cycle ped_req=1 outside PED and FLASH, and clears on PED entry; ped_req during PED or FLASH is ignored.
REQ-021 ped_ack=1 for exactly the one cycle following PED entry.
REQ-022 If ped_req=1 in the same cycle as the AR-to-PED transition, pend is still cleared and no second PED is queued.
REQ-023 FLASH behaviour:
  - xanh_* and do_* are 0.
  - vang_1 and vang_2 are equal and toggle on every tick, starting at 1 on entry.
  - pend is cleared on entry.
  - The timer is held at 0 and the counts are 0.
REQ-024 FLASH exit: on the first tick with night=0, go to AR2 with timer T_ALLRED, then to G1.
REQ-025 night has priority over pend at an AR exit; night changes outside AR exit decision points have no effect until then.
REQ-026 Counts, combinational from state and timer, using unsigned 7-bit sums with no overflow (max 93):
  - Green direction in G*: timer+T_YELLOW.
  - Yellow direction in Y*: timer.
  - Red direction in G*: timer+T_YELLOW+T_ALLRED.
  - Red direction in Y*: timer+T_ALLRED.
  - Both directions in AR*/PED: timer.
REQ-027 Simultaneous tick and reset: reset wins.

Reset
REQ-028 When reset=0 at a clock edge, the next state is:
  - state=G1, timer=T_GREEN, pend=0, next_dir=2.
  - xanh_1=1 and do_2=1; all other lamps, walk and ped_ack are 0.
  - count_1=10 and count_2=11 (defaults).
REQ-029 Reset mid-operation (including in PED or FLASH) behaves identically and discards pending requests.

Verification
REQ-030 Defaults, night=0, no requests, 22 ticks -> G1(7) Y1(3) AR1(1) G2(7) Y2(3) AR2(1), back in G1 at tick 22; count_1 reads 10,9,...,4 across G1.
REQ-031 ped_req pulse during G1 -> after AR1, PED for 5 ticks with walk=1 and a single ped_ack pulse, then G2; the next AR2 goes straight to G1.
REQ-032 ped_req held high through the whole of PED -> no second PED after the following AR2.
REQ-033 night=1 raised during G2 -> Y2, AR2, then FLASH with vang_1/vang_2 toggling per tick; after night drops, the next tick gives AR2 for 1 tick, then G1.
REQ-034 reset=0 asserted in PED with a request pending -> next cycle in G1, walk=0, ped_ack=0, pend=0; the next AR1 goes to G2.
REQ-035 tick asserted at timer=1 in the same cycle as reset=0 -> reset state, no transition.

Source files
------------

// File: rtl/traffic_phase_sched_if.sv
// Signal bundle for the two-way traffic phase scheduler.
//
// Signalling: there is no valid/ready pairing on this block. tick is a
// one-cycle enable that is honoured on the rising edge where it is high.
// ped_req is a level sampled on every edge. ped_ack is a one-cycle pulse that
// the scheduler drives high in the cycle after it enters the walk phase.
// night is a level. The lamps and ped_ack are registered. count_1/count_2 are
// combinational from state and timer. The *_dbg signals show the FSM state,
// the phase timer and the pending-request flag.
interface traffic_phase_sched_if;
  logic       tick;
  logic       ped_req;
  logic       night;
  logic       xanh_1;
  logic       vang_1;
  logic       do_1;
  logic       xanh_2;
  logic       vang_2;
  logic       do_2;
  logic       walk;
  logic       ped_ack;
  logic [6:0] count_1;
  logic [6:0] count_2;
  logic [2:0] state_dbg;
  logic [4:0] timer_dbg;
  logic       pend_dbg;

  modport master (
    output tick, ped_req, night,
    input  xanh_1, vang_1, do_1, xanh_2, vang_2, do_2, walk, ped_ack,
    input  count_1, count_2, state_dbg, timer_dbg, pend_dbg
  );

  modport slave (
    input  tick, ped_req, night,
    output xanh_1, vang_1, do_1, xanh_2, vang_2, do_2, walk, ped_ack,
    output count_1, count_2, state_dbg, timer_dbg, pend_dbg
  );
endinterface

// File: rtl/traffic_phase_sched.sv
// Two-direction traffic light phase scheduler with a pedestrian walk phase
// and a flashing-yellow night mode. Time advances only on the 1 Hz tick.
module traffic_phase_sched #(
  parameter int T_GREEN  = 7,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 5
) (
  input logic clk,
  input logic reset,
  traffic_phase_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_G1    = 3'd0,
    S_Y1    = 3'd1,
    S_AR1   = 3'd2,
    S_G2    = 3'd3,
    S_Y2    = 3'd4,
    S_AR2   = 3'd5,
    S_PED   = 3'd6,
    S_FLASH = 3'd7
  } state_t;

  localparam logic [6:0] TY7 = 7'(T_YELLOW);
  localparam logic [6:0] TA7 = 7'(T_ALLRED);

  // Lamp vector bit order: {xanh_1, vang_1, do_1, xanh_2, vang_2, do_2, walk}
  localparam logic [6:0] L_G1    = 7'b1000010;
  localparam logic [6:0] L_Y1    = 7'b0100010;
  localparam logic [6:0] L_G2    = 7'b0011000;
  localparam logic [6:0] L_Y2    = 7'b0010100;
  localparam logic [6:0] L_AR    = 7'b0010010;
  localparam logic [6:0] L_PED   = 7'b0010011;
  localparam logic [6:0] L_FLASH = 7'b0100100;

  state_t     state_q;
  logic [4:0] timer_q;
  logic       pend_q;
  logic       next_dir2_q;   // 1: the walk phase hands over to G2, 0: to G1
  logic [6:0] lamps_q;
  logic       ped_ack_q;

  state_t     tgt;
  logic       adv;

  // Duration loaded into the timer on entry to each state; FLASH holds 0.
  function automatic logic [4:0] dur(input state_t s);
    case (s)
      S_G1, S_G2:   dur = 5'(T_GREEN);
      S_Y1, S_Y2:   dur = 5'(T_YELLOW);
      S_AR1, S_AR2: dur = 5'(T_ALLRED);
      S_PED:        dur = 5'(T_WALK);
      default:      dur = 5'd0;
    endcase
  endfunction

  // Lamp pattern presented on entry to each state.
  function automatic logic [6:0] lamps_for(input state_t s);
    case (s)
      S_G1:         lamps_for = L_G1;
      S_Y1:         lamps_for = L_Y1;
      S_G2:         lamps_for = L_G2;
      S_Y2:         lamps_for = L_Y2;
      S_AR1, S_AR2: lamps_for = L_AR;
      S_PED:        lamps_for = L_PED;
      default:      lamps_for = L_FLASH;
    endcase
  endfunction

  // Successor state and whether this edge takes the transition.
  always_comb begin
    tgt = state_q;
    adv = bus.tick && (timer_q == 5'd1);
    case (state_q)
      S_G1:    tgt = S_Y1;
      S_Y1:    tgt = S_AR1;
      S_AR1:   tgt = bus.night ? S_FLASH : (pend_q ? S_PED : S_G2);
      S_G2:    tgt = S_Y2;
      S_Y2:    tgt = S_AR2;
      S_AR2:   tgt = bus.night ? S_FLASH : (pend_q ? S_PED : S_G1);
      S_PED:   tgt = next_dir2_q ? S_G2 : S_G1;
      S_FLASH: begin
        tgt = S_AR2;
        adv = bus.tick && !bus.night;
      end
      default: ;
    endcase
  end

  // Phase FSM: state, timer, pending request, hand-over direction and lamps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_G1;
      timer_q     <= 5'(T_GREEN);
      pend_q      <= 1'b0;
      next_dir2_q <= 1'b1;
      lamps_q     <= L_G1;
      ped_ack_q   <= 1'b0;
    end else begin
      ped_ack_q <= 1'b0;
      if (bus.ped_req && state_q != S_PED && state_q != S_FLASH)
        pend_q <= 1'b1;
      if (adv) begin
        state_q <= tgt;
        timer_q <= dur(tgt);
        lamps_q <= lamps_for(tgt);
        // Entering PED or FLASH consumes the request, even one arriving now.
        if (tgt == S_PED) begin
          pend_q      <= 1'b0;
          ped_ack_q   <= 1'b1;
          next_dir2_q <= (state_q == S_AR1);
        end
        if (tgt == S_FLASH)
          pend_q <= 1'b0;
      end else if (bus.tick) begin
        if (state_q == S_FLASH) begin
          lamps_q[5] <= ~lamps_q[5];
          lamps_q[2] <= ~lamps_q[2];
        end else begin
          timer_q <= timer_q - 5'd1;
        end
      end
    end
  end

  // Seconds until each direction's next lamp change.
  always_comb begin
    logic [6:0] tm7;
    tm7         = {2'b00, timer_q};
    bus.count_1 = 7'd0;
    bus.count_2 = 7'd0;
    case (state_q)
      S_G1: begin
        bus.count_1 = tm7 + TY7;
        bus.count_2 = tm7 + TY7 + TA7;
      end
      S_Y1: begin
        bus.count_1 = tm7;
        bus.count_2 = tm7 + TA7;
      end
      S_G2: begin
        bus.count_1 = tm7 + TY7 + TA7;
        bus.count_2 = tm7 + TY7;
      end
      S_Y2: begin
        bus.count_1 = tm7 + TA7;
        bus.count_2 = tm7;
      end
      S_AR1, S_AR2, S_PED: begin
        bus.count_1 = tm7;
        bus.count_2 = tm7;
      end
      default: ;
    endcase
  end

  assign bus.xanh_1    = lamps_q[6];
  assign bus.vang_1    = lamps_q[5];
  assign bus.do_1      = lamps_q[4];
  assign bus.xanh_2    = lamps_q[3];
  assign bus.vang_2    = lamps_q[2];
  assign bus.do_2      = lamps_q[1];
  assign bus.walk      = lamps_q[0];
  assign bus.ped_ack   = ped_ack_q;
  assign bus.state_dbg = state_q;
  assign bus.timer_dbg = timer_q;
  assign bus.pend_dbg  = pend_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched with default parameters.
module tb_traffic_phase_sched;

  localparam logic [2:0] G1 = 3'd0, Y1 = 3'd1, AR1 = 3'd2, G2 = 3'd3;
  localparam logic [2:0] Y2 = 3'd4, AR2 = 3'd5, PED = 3'd6, FL = 3'd7;

  // {xanh_1, vang_1, do_1, xanh_2, vang_2, do_2, walk}
  localparam logic [6:0] LG1 = 7'b1000010, LY1 = 7'b0100010;
  localparam logic [6:0] LG2 = 7'b0011000, LY2 = 7'b0010100;
  localparam logic [6:0] LAR = 7'b0010010, LPD = 7'b0010011;
  localparam logic [6:0] LFL = 7'b0100100, LOF = 7'b0000000;

  typedef struct {
    int         ticks;
    logic       ped;
    logic       night;
    logic [2:0] st;
    logic [4:0] tm;
    logic [6:0] lamps;
    logic [6:0] c1;
    logic [6:0] c2;
    logic       pend;
    int         acks;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   ack_cnt;

  traffic_phase_sched_if bus();

  traffic_phase_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ped_ack pulses, sampled mid-cycle.
  always @(negedge clk) if (bus.ped_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  function automatic logic [6:0] lamps_now();
    return {bus.xanh_1, bus.vang_1, bus.do_1, bus.xanh_2, bus.vang_2,
            bus.do_2, bus.walk};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One tick pulse seen by exactly one rising edge.
  task automatic do_tick();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
  endtask

  task automatic pulse_ped();
    @(negedge clk) bus.ped_req = 1'b1;
    @(negedge clk) bus.ped_req = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    #1;
    chk({tag, " state"}, 32'(bus.state_dbg), 32'(v.st));
    chk({tag, " timer"}, 32'(bus.timer_dbg), 32'(v.tm));
    chk({tag, " lamps"}, 32'(lamps_now()), 32'(v.lamps));
    chk({tag, " count_1"}, 32'(bus.count_1), 32'(v.c1));
    chk({tag, " count_2"}, 32'(bus.count_2), 32'(v.c2));
    chk({tag, " pend"}, 32'(bus.pend_dbg), 32'(v.pend));
    chk({tag, " acks"}, 32'(ack_cnt), 32'(v.acks));
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    int base_ack;
    errors = 0;
    checks = 0;
    ack_cnt = 0;
    reset = 1'b0;
    bus.tick = 1'b0;
    bus.ped_req = 1'b0;
    bus.night = 1'b0;

    //            ticks ped night st   tm  lamps c1  c2 pend acks
    vecs.push_back('{0,  0, 0, G1,  7, LG1, 10, 11, 0, 0});
    vecs.push_back('{1,  0, 0, G1,  6, LG1,  9, 10, 0, 0});
    vecs.push_back('{5,  0, 0, G1,  1, LG1,  4,  5, 0, 0});
    vecs.push_back('{1,  0, 0, Y1,  3, LY1,  3,  4, 0, 0});
    vecs.push_back('{2,  0, 0, Y1,  1, LY1,  1,  2, 0, 0});
    vecs.push_back('{1,  0, 0, AR1, 1, LAR,  1,  1, 0, 0});
    vecs.push_back('{1,  0, 0, G2,  7, LG2, 11, 10, 0, 0});
    vecs.push_back('{7,  0, 0, Y2,  3, LY2,  4,  3, 0, 0});
    vecs.push_back('{3,  0, 0, AR2, 1, LAR,  1,  1, 0, 0});
    vecs.push_back('{1,  0, 0, G1,  7, LG1, 10, 11, 0, 0});
    vecs.push_back('{0,  1, 0, G1,  7, LG1, 10, 11, 1, 0});
    vecs.push_back('{10, 0, 0, AR1, 1, LAR,  1,  1, 1, 0});
    vecs.push_back('{1,  0, 0, PED, 5, LPD,  5,  5, 0, 1});
    vecs.push_back('{4,  0, 0, PED, 1, LPD,  1,  1, 0, 1});
    vecs.push_back('{1,  0, 0, G2,  7, LG2, 11, 10, 0, 1});
    vecs.push_back('{11, 0, 0, G1,  7, LG1, 10, 11, 0, 1});
    vecs.push_back('{11, 0, 0, G2,  7, LG2, 11, 10, 0, 1});
    vecs.push_back('{0,  0, 1, G2,  7, LG2, 11, 10, 0, 1});
    vecs.push_back('{10, 0, 1, AR2, 1, LAR,  1,  1, 0, 1});
    vecs.push_back('{1,  0, 1, FL,  0, LFL,  0,  0, 0, 1});
    vecs.push_back('{1,  0, 1, FL,  0, LOF,  0,  0, 0, 1});
    vecs.push_back('{1,  0, 1, FL,  0, LFL,  0,  0, 0, 1});
    vecs.push_back('{0,  1, 1, FL,  0, LFL,  0,  0, 0, 1});
    vecs.push_back('{1,  0, 0, AR2, 1, LAR,  1,  1, 0, 1});
    vecs.push_back('{1,  0, 0, G1,  7, LG1, 10, 11, 0, 1});

    do_reset();

    // Table-driven run from reset.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk) bus.night = vecs[i].night;
      if (vecs[i].ped) pulse_ped();
      for (int k = 0; k < vecs[i].ticks; k++) do_tick();
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Request held through the whole walk phase: one walk, one ack.
    base_ack = ack_cnt;
    pulse_ped();
    for (int k = 0; k < 10; k++) do_tick();
    #1 chk("hold at AR1", 32'(bus.state_dbg), 32'(AR1));
    @(negedge clk) bus.ped_req = 1'b1;
    do_tick();
    #1 chk("hold PED entry", 32'(bus.state_dbg), 32'(PED));
    chk("hold pend cleared at entry", 32'(bus.pend_dbg), 32'd0);
    chk("ack high after entry", 32'(bus.ped_ack), 32'd1);
    @(negedge clk) #1 chk("ack one cycle", 32'(bus.ped_ack), 32'd0);
    for (int k = 0; k < 5; k++) do_tick();
    bus.ped_req = 1'b0;
    #1 chk("hold exit to G2", 32'(bus.state_dbg), 32'(G2));
    chk("hold no pend", 32'(bus.pend_dbg), 32'd0);
    for (int k = 0; k < 11; k++) do_tick();
    #1 chk("hold AR2 to G1", 32'(bus.state_dbg), 32'(G1));
    chk("hold single ack", 32'(ack_cnt - base_ack), 32'd1);

    // Reset in PED with a request being raised.
    pulse_ped();
    for (int k = 0; k < 11; k++) do_tick();
    #1 chk("rst pre PED", 32'(bus.state_dbg), 32'(PED));
    @(negedge clk) begin
      bus.ped_req = 1'b1;
      reset = 1'b0;
    end
    @(negedge clk) begin
      bus.ped_req = 1'b0;
      reset = 1'b1;
    end
    #1 chk("rst state", 32'(bus.state_dbg), 32'(G1));
    chk("rst lamps", 32'(lamps_now()), 32'(LG1));
    chk("rst ack", 32'(bus.ped_ack), 32'd0);
    chk("rst pend", 32'(bus.pend_dbg), 32'd0);
    chk("rst count_1", 32'(bus.count_1), 32'd10);
    chk("rst count_2", 32'(bus.count_2), 32'd11);
    for (int k = 0; k < 11; k++) do_tick();
    #1 chk("rst AR1 to G2", 32'(bus.state_dbg), 32'(G2));

    // Tick at timer=1 together with reset: reset wins.
    do_reset();
    for (int k = 0; k < 6; k++) do_tick();
    #1 chk("tr timer 1", 32'(bus.timer_dbg), 32'd1);
    @(negedge clk) begin
      bus.tick = 1'b1;
      reset = 1'b0;
    end
    @(negedge clk) begin
      bus.tick = 1'b0;
      reset = 1'b1;
    end
    #1 chk("tr state", 32'(bus.state_dbg), 32'(G1));
    chk("tr timer", 32'(bus.timer_dbg), 32'd7);

    // Reset during FLASH returns to G1.
    @(negedge clk) bus.night = 1'b1;
    for (int k = 0; k < 23; k++) do_tick();
    #1 chk("fl reached", 32'(bus.state_dbg), 32'(FL));
    do_reset();
    #1 chk("fl rst state", 32'(bus.state_dbg), 32'(G1));
    chk("fl rst lamps", 32'(lamps_now()), 32'(LG1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
